dma_copier: RTL and testbench
=============================

DMA_COPIER -- requirements
Module: dma_copier

Interface
REQ-001 Parameter: ADDR_W, 16, bus address width in bits.
REQ-002 Parameter: DATA_W, 16, bus data width in bits.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  copy request, sampled only in IDLE.
REQ-006 Port: abort  in  1  level; stop after the outstanding transaction completes.
REQ-007 Port: src_addr  in  ADDR_W  first source word address, latched on accepted start.
REQ-008 Port: dst_addr  in  ADDR_W  first destination word address, latched on accepted start.
REQ-009 Port: length  in  16  word count, latched on accepted start; 0 = no transfer.
REQ-010 Port: busy  out  1  high in every state except IDLE.
REQ-011 Port: done_pulse  out  1  one-cycle completion strobe.
REQ-012 Port: count  out  16  words fully copied (write acknowledged) in the current or last job.
REQ-013 Port: bus_addr  out  ADDR_W  transaction address.
REQ-014 Port: bus_cmd  out  2  00 nop, 01 read, 10 write.
REQ-015 Port: bus_run  out  1  request toggle; each toggle issues one transaction.
REQ-016 Port: bus_wr_data  out  DATA_W  write data.
REQ-017 Port: bus_rd_data  in  DATA_W  read data; valid when bus_run == bus_done after a read.
REQ-018 Port: bus_done  in  1  responder completion toggle.

Function
REQ-019 Block SHALL be a toggle-handshake bus initiator: a transaction is outstanding while bus_run != bus_done.
REQ-020 bus_addr, bus_cmd, and bus_wr_data SHALL change only in the same cycle bus_run toggles, or in DONE. They SHALL stay stable while a transaction is outstanding.
REQ-021 bus_run SHALL never toggle while a transaction is outstanding.
REQ-022 States SHALL be IDLE, RD_WAIT, WR_WAIT, and DONE.
REQ-023 IDLE with start=1 and length!=0 SHALL do the following at the next edge:
- latch src, dst, and length;
- set count=0;
- set bus_addr=src_addr and bus_cmd=01;
- toggle bus_run;
- move to RD_WAIT.
REQ-024 IDLE with start=1 and length=0 SHALL set count=0 and move to DONE with no bus toggle.
REQ-025 RD_WAIT with bus_run==bus_done and abort=0 SHALL do the following at the next edge:
- set bus_wr_data=bus_rd_data;
- set bus_addr=dst+count and bus_cmd=10;
- toggle bus_run;
- move to WR_WAIT.
REQ-026 RD_WAIT with bus_run==bus_done and abort=1 SHALL move to DONE with count unchanged.
REQ-027 WR_WAIT with bus_run==bus_done SHALL increment count.
- If the new count equals length, or abort=1, it SHALL move to DONE.
- Otherwise it SHALL set bus_addr=src+new count and bus_cmd=01, toggle bus_run, and move to RD_WAIT.
REQ-028 DONE SHALL assert done_pulse for exactly that one cycle, set bus_cmd=00, and return to IDLE.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; wrap-around from 0xFFFF to 0x0000 is legal and silent.
REQ-030 start while busy=1 SHALL be ignored with no effect on the current job.
REQ-031 When start and abort are both 1 in IDLE, start SHALL win and abort SHALL be evaluated only at the first completion.
REQ-032 Minimum cost per word SHALL be 4 cycles with a 1-cycle responder: read issue, read done, write issue, write done.
REQ-033 count SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-034 reset_n=0 SHALL immediately force the following, at any state including mid-transaction:
- state IDLE;
- busy=0, done_pulse=0, count=0;
- bus_addr=0, bus_cmd=00, bus_run=0, bus_wr_data=0.
REQ-035 The system SHALL reset the responder together with this block so that bus_done returns to 0. Releasing reset with bus_done=1 is outside this block's contract.
REQ-036 After reset release, the first accepted start SHALL behave per REQ-023.

Verification
REQ-037 Copy: memory [0x10..0x13]={A1,B2,C3,D4}, start with src=0x10, dst=0x40, length=4, 1-cycle responder.
- Required: mem[0x40..0x43]={A1,B2,C3,D4};
- count=4;
- exactly 8 bus_run toggles;
- one done_pulse;
- busy high for 17 cycles.
REQ-038 Zero length: start with length=0.
- Required: done_pulse one cycle later;
- no bus_run toggle;
- count=0.
REQ-039 Wrap: src=0xFFFE, dst=0x0100, length=3.
- Required: reads at 0xFFFE, 0xFFFF, 0x0000;
- writes at 0x0100..0x0102.
REQ-040 Abort: random 0-5 cycle responder latency, length=8, abort asserted during the third read.
- Required: no write for word 3;
- count=2;
- done_pulse;
- bus_run never toggles while outstanding.
REQ-041 Busy start: second start with different src/dst/length mid-job.
- Required: ignored, and the first job completes unchanged.
REQ-042 Reset: reset_n pulsed low during WR_WAIT.
- Required: all outputs at reset values asynchronously;
- a new job after release completes correctly.

Source files
------------

// File: rtl/dma_copier_if.sv
// Toggle-handshake bus between the copy engine (master) and a memory responder (slave).
// A transaction is outstanding while bus_run != bus_done.
interface dma_copier_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_cmd;
  logic              bus_run;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_done;

  modport master (
    output bus_addr, bus_cmd, bus_run, bus_wr_data,
    input  bus_rd_data, bus_done
  );

  modport slave (
    input  bus_addr, bus_cmd, bus_run, bus_wr_data,
    output bus_rd_data, bus_done
  );
endinterface

// File: rtl/dma_copier.sv
// Word-by-word memory copy engine: read src+i, write dst+i, over a toggle-handshake bus.
// Abort is honoured only when the outstanding transaction has completed.
module dma_copier #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done_pulse,
  output logic [15:0]       count,
  dma_copier_if.master      bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT, S_DONE} state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            r_state,   w_next_state;
  logic [ADDR_W-1:0] r_src,     w_src;
  logic [ADDR_W-1:0] r_dst,     w_dst;
  logic [15:0]       r_len,     w_len;
  logic [15:0]       r_count,   w_count;
  logic [ADDR_W-1:0] r_addr,    w_addr;
  logic [1:0]        r_cmd,     w_cmd;
  logic              r_run,     w_run;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;

  logic              w_complete;
  logic [15:0]       w_count_inc;

  assign w_complete  = (r_run == bus.bus_done);
  assign w_count_inc = r_count + 16'd1;

  // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_src        = r_src;
    w_dst        = r_dst;
    w_len        = r_len;
    w_count      = r_count;
    w_addr       = r_addr;
    w_cmd        = r_cmd;
    w_run        = r_run;
    w_wr_data    = r_wr_data;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src   = src_addr;
          w_dst   = dst_addr;
          w_len   = length;
          w_count = '0;
          if (length != 16'd0) begin
            w_addr       = src_addr;
            w_cmd        = CMD_READ;
            w_run        = ~r_run;
            w_next_state = S_RD_WAIT;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end

      S_RD_WAIT: begin
        if (w_complete) begin
          if (abort) begin
            w_next_state = S_DONE;
          end else begin
            w_wr_data    = bus.bus_rd_data;
            w_addr       = r_dst + ADDR_W'(r_count);
            w_cmd        = CMD_WRITE;
            w_run        = ~r_run;
            w_next_state = S_WR_WAIT;
          end
        end
      end

      S_WR_WAIT: begin
        if (w_complete) begin
          w_count = w_count_inc;
          if (w_count_inc == r_len || abort) begin
            w_next_state = S_DONE;
          end else begin
            w_addr       = r_src + ADDR_W'(w_count_inc);
            w_cmd        = CMD_READ;
            w_run        = ~r_run;
            w_next_state = S_RD_WAIT;
          end
        end
      end

      S_DONE: begin
        w_cmd        = CMD_NOP;
        w_next_state = S_IDLE;
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_cmd     <= CMD_NOP;
      r_run     <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_next_state;
      r_src     <= w_src;
      r_dst     <= w_dst;
      r_len     <= w_len;
      r_count   <= w_count;
      r_addr    <= w_addr;
      r_cmd     <= w_cmd;
      r_run     <= w_run;
      r_wr_data <= w_wr_data;
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign done_pulse      = (r_state == S_DONE);
  assign count           = r_count;
  assign bus.bus_addr    = r_addr;
  assign bus.bus_cmd     = r_cmd;
  assign bus.bus_run     = r_run;
  assign bus.bus_wr_data = r_wr_data;

endmodule

// File: tb/tb_dma_copier.sv
// Self-checking bench for dma_copier: memory responder with random latency, protocol
// monitor, and a sequential word-copy reference model over a shadow memory.
module tb_dma_copier;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [15:0]   length = '0;
  logic          busy;
  logic          done_pulse;
  logic [15:0]   count;

  dma_copier_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dma_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done_pulse (done_pulse),
    .count      (count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      16'h10:  return 16'h00A1;
      16'h11:  return 16'h00B2;
      16'h12:  return 16'h00C3;
      16'h13:  return 16'h00D4;
      default: return 16'(a * 40503 + 12345);
    endcase
  endfunction

  // Responder: completes a transaction lat_cur cycles after it sees it outstanding.
  logic [DW-1:0] mem [0:65535];
  logic          mem_filled = 1'b0;
  int            lat_max = 0;
  int            lat_cur = 0;
  int            wait_cnt = 0;
  txn_t          act_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.bus_done    <= 1'b0;
      bus.bus_rd_data <= '0;
      wait_cnt        <= 0;
      if (!mem_filled) begin
        for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
        mem_filled <= 1'b1;
      end
    end else if (bus.bus_run != bus.bus_done) begin
      if (wait_cnt >= lat_cur) begin
        bus.bus_done <= bus.bus_run;
        wait_cnt     <= 0;
        lat_cur      <= $urandom_range(lat_max, 0);
        if (bus.bus_cmd == 2'b01) begin
          bus.bus_rd_data <= mem[bus.bus_addr];
          act_q.push_back(txn_t'({2'b01, bus.bus_addr, mem[bus.bus_addr]}));
        end else if (bus.bus_cmd == 2'b10) begin
          mem[bus.bus_addr] <= bus.bus_wr_data;
          act_q.push_back(txn_t'({2'b10, bus.bus_addr, bus.bus_wr_data}));
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Monitor: free-running totals of toggles, busy cycles, done strobes, protocol violations.
  int            n_tog = 0, n_busy = 0, n_done = 0, n_viol = 0;
  logic          p_valid = 1'b0, p_run = 1'b0, p_done = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [1:0]    p_cmd = '0;
  logic [DW-1:0] p_wd = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_valid <= 1'b0;
    end else begin
      if (p_valid && p_run != p_done &&
          (bus.bus_run != p_run || bus.bus_addr != p_addr ||
           bus.bus_cmd != p_cmd || bus.bus_wr_data != p_wd))
        n_viol <= n_viol + 1;
      if (p_valid && bus.bus_run != p_run) n_tog <= n_tog + 1;
      if (busy) n_busy <= n_busy + 1;
      if (done_pulse) n_done <= n_done + 1;
      p_valid <= 1'b1;
      p_run   <= bus.bus_run;
      p_done  <= bus.bus_done;
      p_addr  <= bus.bus_addr;
      p_cmd   <= bus.bus_cmd;
      p_wd    <= bus.bus_wr_data;
    end
  end

  // Reference model: plain sequential copy over a shadow memory.
  logic [DW-1:0] ref_mem [0:65535];
  txn_t          exp_q[$];

  task automatic model_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input int abort_at, output logic [15:0] exp_cnt);
    int n;
    logic [15:0] sa, da;
    exp_q.delete();
    n = (abort_at >= 0 && abort_at < int'(l)) ? abort_at : int'(l);
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_q.push_back(txn_t'({2'b01, sa, ref_mem[sa]}));
      ref_mem[da] = ref_mem[sa];
      exp_q.push_back(txn_t'({2'b10, da, ref_mem[da]}));
    end
    if (n < int'(l)) begin
      sa = s + 16'(n);
      exp_q.push_back(txn_t'({2'b01, sa, ref_mem[sa]}));
    end
    exp_cnt = 16'(n);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int job_base, job_done_cyc, job_busy, job_tog, job_dones, job_viol;

  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int abort_at, input int intrude_at);
    int b0, t0, d0, v0;
    logic fin;
    logic [15:0] ab_addr;
    ab_addr = s + 16'(abort_at);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    b0 = n_busy; t0 = n_tog; d0 = n_done; v0 = n_viol;
    job_base = act_q.size();
    job_done_cyc = -1;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == intrude_at) begin
        start = 1'b1; src_addr = ~s; dst_addr = s; length = l + 16'd3;
      end
      if (abort_at >= 0 && !abort && bus.bus_cmd == 2'b01 &&
          bus.bus_run != bus.bus_done && bus.bus_addr == ab_addr)
        abort = 1'b1;
      if (done_pulse) begin
        fin = 1'b1;
        job_done_cyc = cyc;
      end
    end
    check("job_timeout", fin, 1'b1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    job_busy  = n_busy - b0;
    job_tog   = n_tog - t0;
    job_dones = n_done - d0;
    job_viol  = n_viol - v0;
  endtask

  task automatic check_job(input string tag, input logic [15:0] exp_cnt);
    check({tag, "_count"}, count, exp_cnt);
    check({tag, "_dones"}, job_dones, 1);
    check({tag, "_viol"}, job_viol, 0);
    check({tag, "_ntxn"}, act_q.size() - job_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (job_base + i < act_q.size())
        check({tag, "_txn"}, act_q[job_base + i], exp_q[i]);
    foreach (exp_q[i])
      if (exp_q[i].cmd == 2'b10)
        check({tag, "_mem"}, mem[exp_q[i].addr], ref_mem[exp_q[i].addr]);
  endtask

  initial begin
    logic [15:0] ec, s, d, l;
    logic [15:0] pat [4];
    logic found;
    pat = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

    #1 reset_n = 1'b0;
    #20;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_pulse, 1'b0);
    check("rst_count", count, 16'd0);
    check("rst_addr", bus.bus_addr, 16'd0);
    check("rst_cmd", bus.bus_cmd, 2'b00);
    check("rst_run", bus.bus_run, 1'b0);
    check("rst_wdata", bus.bus_wr_data, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic 4-word copy with a 1-cycle responder
    lat_max = 0;
    model_job(16'h0010, 16'h0040, 16'd4, -1, ec);
    run_job(16'h0010, 16'h0040, 16'd4, -1, -1);
    check_job("copy", ec);
    check("copy_toggles", job_tog, 8);
    check("copy_busy_cycles", job_busy, 17);
    for (int i = 0; i < 4; i++) check("copy_pattern", mem[16'h0040 + 16'(i)], pat[i]);
    check("copy_cmd_idle", bus.bus_cmd, 2'b00);
    repeat (3) @(negedge clk);
    check("count_hold", count, 16'd4);

    // Zero length
    model_job(16'h0200, 16'h0300, 16'd0, -1, ec);
    run_job(16'h0200, 16'h0300, 16'd0, -1, -1);
    check_job("zero", ec);
    check("zero_latency", job_done_cyc, 1);
    check("zero_toggles", job_tog, 0);

    // Address wrap-around
    model_job(16'hFFFE, 16'h0100, 16'd3, -1, ec);
    run_job(16'hFFFE, 16'h0100, 16'd3, -1, -1);
    check_job("wrap", ec);
    check("wrap_rd2_addr", act_q[job_base + 4].addr, 16'h0000);

    // Abort during the third read, random latency
    lat_max = 5;
    s = 16'($urandom); d = s + 16'h4000;
    model_job(s, d, 16'd8, 2, ec);
    run_job(s, d, 16'd8, 2, -1);
    check_job("abort", ec);
    check("abort_count2", count, 16'd2);

    // Start and abort together in IDLE: start wins, abort seen at first completion
    abort = 1'b1;
    s = 16'($urandom); d = s + 16'h2000;
    model_job(s, d, 16'd5, 0, ec);
    run_job(s, d, 16'd5, 0, -1);
    check_job("start_abort", ec);

    // Start while busy is ignored
    s = 16'($urandom); d = s + 16'h1000;
    model_job(s, d, 16'd5, -1, ec);
    run_job(s, d, 16'd5, -1, 6);
    check_job("busy_start", ec);

    // Random jobs
    for (int k = 0; k < 4; k++) begin
      s = 16'($urandom); d = 16'($urandom); l = 16'($urandom_range(6, 1));
      model_job(s, d, l, -1, ec);
      run_job(s, d, l, -1, -1);
      check_job("rand", ec);
    end

    // Reset during the second write, then a fresh job
    s = 16'h2000; d = 16'h3000;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (bus.bus_cmd == 2'b10 && bus.bus_run != bus.bus_done && bus.bus_addr == d + 16'd1)
        found = 1'b1;
    end
    check("rst_reach_wr", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done_pulse, 1'b0);
    check("mid_rst_count", count, 16'd0);
    check("mid_rst_addr", bus.bus_addr, 16'd0);
    check("mid_rst_cmd", bus.bus_cmd, 2'b00);
    check("mid_rst_run", bus.bus_run, 1'b0);
    check("mid_rst_wdata", bus.bus_wr_data, 16'd0);
    ref_mem[d] = ref_mem[s];
    @(negedge clk);
    reset_n = 1'b1;
    model_job(16'h2100, d, 16'd4, -1, ec);
    run_job(16'h2100, d, 16'd4, -1, -1);
    check_job("post_rst", ec);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
